alu_op_responder: RTL and testbench
===================================

// Module: alu_op_responder
// PURPOSE
//  Request/response wrapper around the team ALU opcode set. Accepts one operation per
//  valid/ready handshake, executes it (shifts serially, one bit per cycle), and returns
//  result, zero flag and echoed tag on a registered valid/ready response channel.
//  It is the responder that an ALU stimulus driver or a sequencer talks to.
// PARAMETERS
//  WIDTH  32  operand/result width; power of 2, >= 8
//  TAG_W  4   width of request tag echoed on response
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  req_valid  in   1           request present
//  req_ready  out  1           responder can accept (high only in IDLE)
//  req_a      in   WIDTH       operand A; for shifts, A[log2(WIDTH)-1:0] = shift amount
//  req_b      in   WIDTH       operand B; value shifted for shifts
//  req_aluc   in   4           opcode
//  req_tag    in   TAG_W       opaque tag
//  rsp_valid  out  1           response present
//  rsp_ready  in   1           consumer accepts response
//  rsp_r      out  WIDTH       result
//  rsp_z      out  1           1 when rsp_r == 0
//  rsp_tag    out  TAG_W       tag of the request that produced the response
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 after reset release; rsp_valid=0, rsp_r=0, rsp_z=1, rsp_tag=0.
//  - Opcodes (x = don't care): x000 ADD a+b; x100 SUB a-b; x001 AND; x101 OR; x010 XOR;
//    x110 LUI = b[WIDTH/2-1:0] << WIDTH/2; 0011/1011 SLL b<<sh; 0111 SRL b>>sh (logical);
//    1111 SRA b>>>sh (arithmetic). All 16 codes are legal. Arithmetic wraps mod 2^WIDTH.
//  - FSM IDLE/SHIFT/DONE. Accept = req_valid & req_ready on a rising edge; operands, opcode, tag registered.
//    IDLE -> DONE: non-shift op, or shift with sh==0 (result computed at accept edge).
//    IDLE -> SHIFT: shift with sh>0; load b into a shift register, counter = sh.
//    SHIFT: each cycle shift 1 bit (SRA replicates MSB), counter-1; at counter==1 -> DONE.
//    DONE: rsp_valid=1; on rsp_valid & rsp_ready -> IDLE.
//  - Latency: rsp_valid asserted in cycle after accept edge for non-shift/sh==0;
//    sh>0 adds exactly sh cycles. Throughput at most 1 op per 2 cycles (req_ready=0 in SHIFT/DONE).
//  - rsp_r, rsp_z, rsp_tag stable while rsp_valid & !rsp_ready; may change only on handshake.
//  - rsp_z from registered result, valid with rsp_valid.
//  - req_* ignored while req_ready=0; a request held valid is accepted on the first IDLE cycle.
//  - No accept in the same cycle as the response handshake; IDLE entered first.
//  - Async reset mid-SHIFT or mid-DONE: op discarded, outputs take reset values immediately.
// CONFIGURATION
//  ALU_OVF_FLAG_EN defined: extra output rsp_ovf (1 bit), registered with rsp_r;
//    1 when ADD/SUB signed overflow, 0 for every other opcode; reset value 0.
//  Undefined: rsp_ovf port and its logic absent; all other behaviour identical.
// TESTING
//  1 ADD a=10 b=3 aluc=0000 tag=5, rsp_ready=1 -> rsp_valid 1 cycle after accept, r=13, z=0, tag=5.
//  2 SUB a=3 b=3 aluc=0100 -> r=0, z=1; AND 10,3 (0001) -> r=2; LUI b=0x1234 (0110) -> 0x12340000.
//  3 SRA a=4 b=0x80000000 aluc=1111 -> r=0xF8000000, rsp_valid 5 cycles after accept;
//    SRL same operands (0111) -> 0x08000000; SLL a=0 b=7 (0011) -> r=7 with 1-cycle latency.
//  4 Backpressure: rsp_ready=0 for 3 cycles after rsp_valid -> r/z/tag stable, req_ready=0,
//    pending request held; accepted on the cycle after the rsp_ready=1 handshake.
//  5 rst_n low during SHIFT of SLL a=20 -> rsp_valid never asserts for it, outputs reset at once,
//    req_ready=1 after release; next ADD 1+1 returns r=2.
//  6 With ALU_OVF_FLAG_EN: ADD 0x7FFFFFFF+1 -> r=0x80000000, ovf=1; SUB 0x80000000-1 -> ovf=1;
//    ADD 10+3 -> ovf=0; XOR 0x7FFFFFFF,0xFFFFFFFF -> ovf=0.

Source files
------------

// File: rtl/alu_op_responder.sv
// Request/response ALU wrapper: one op per handshake, serial shifter, registered response.
// Optional `define ALU_OVF_FLAG_EN adds the rsp_ovf signed-overflow output for ADD/SUB.
`timescale 1ns/1ps
module alu_op_responder #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [3:0]       req_aluc,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_r,
   output logic             rsp_z,
   output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_OVF_FLAG_EN
   ,
   output logic             rsp_ovf
`endif
);

   localparam int SH_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shift_nxt;
   logic [SH_W-1:0]  cnt;
   logic             sll_mode, sra_mode;
   logic             accept, start_shift;
   logic [SH_W-1:0]  sh;
   logic [WIDTH-1:0] alu_r;

   assign req_ready   = (state == S_IDLE);
   assign rsp_valid   = (state == S_DONE);
   assign accept      = req_valid & req_ready;
   assign sh          = req_a[SH_W-1:0];
   assign start_shift = (req_aluc[1:0] == 2'b11) && (sh != '0);
   assign rsp_z       = (rsp_r == '0);

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      alu_r = req_b;
      case (req_aluc[2:0])
         3'b000:  alu_r = req_a + req_b;
         3'b100:  alu_r = req_a - req_b;
         3'b001:  alu_r = req_a & req_b;
         3'b101:  alu_r = req_a | req_b;
         3'b010:  alu_r = req_a ^ req_b;
         3'b110:  alu_r = {req_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         default: alu_r = req_b;  // shift by zero passes b through
      endcase
   end

   always_comb begin
      shift_nxt = {sra_mode & shreg[WIDTH-1], shreg[WIDTH-1:1]};
      if (sll_mode) shift_nxt = {shreg[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = start_shift ? S_SHIFT : S_DONE;
         S_SHIFT: if (cnt == SH_W'(1)) state_nxt = S_DONE;
         S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the shifter datapath is reset too, so an aborted op leaves no stale value behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= '0;
         cnt      <= '0;
         sll_mode <= 1'b0;
         sra_mode <= 1'b0;
         rsp_r    <= '0;
         rsp_tag  <= '0;
      end else if (accept) begin
         shreg    <= req_b;
         cnt      <= sh;
         sll_mode <= ~req_aluc[2];
         sra_mode <= req_aluc[3];
         rsp_tag  <= req_tag;
         if (!start_shift) rsp_r <= alu_r;
      end else if (state == S_SHIFT) begin
         // the last serial step writes the result straight into the response register
         shreg <= shift_nxt;
         cnt   <= cnt - 1'b1;
         if (cnt == SH_W'(1)) rsp_r <= shift_nxt;
      end
   end

`ifdef ALU_OVF_FLAG_EN
   logic alu_ovf;

   always_comb begin
      alu_ovf = 1'b0;
      case (req_aluc[2:0])
         3'b000:  alu_ovf = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (alu_r[WIDTH-1] != req_a[WIDTH-1]);
         3'b100:  alu_ovf = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (alu_r[WIDTH-1] != req_a[WIDTH-1]);
         default: alu_ovf = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rsp_ovf <= 1'b0;
      else if (accept) rsp_ovf <= alu_ovf;
   end
`endif

endmodule

// File: tb/tb_alu_op_responder.sv
// Scoreboard bench for alu_op_responder: driver pushes expected responses, monitor pops and compares.
`timescale 1ns/1ps
module tb_alu_op_responder;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_aluc;
   logic [3:0]  req_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_r;
   logic        rsp_z;
   logic [3:0]  rsp_tag;
`ifdef ALU_OVF_FLAG_EN
   logic        rsp_ovf;
`endif

   alu_op_responder #(.WIDTH(32), .TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_aluc  (req_aluc),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_r     (rsp_r),
      .rsp_z     (rsp_z),
      .rsp_tag   (rsp_tag)
`ifdef ALU_OVF_FLAG_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   typedef struct {
      logic [31:0] r;
      logic [3:0]  tag;
      logic        ovf;
      int          acc;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   n_vec   = 0;
   int   n_err   = 0;
   int   cyc     = 0;
   int   last_acc = 0;
   int   hs_cyc  = 0;
   bit   seen    = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                 output logic [31:0] r, output logic ovf, output int lat);
      int unsigned sh;
      longint      s;
      sh  = a[4:0];
      ovf = 1'b0;
      lat = 1;
      s   = 0;
      case (op[2:0])
         3'b000: begin
            r = a + b;
            s = longint'($signed(a)) + longint'($signed(b));
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'b100: begin
            r = a - b;
            s = longint'($signed(a)) - longint'($signed(b));
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'b001: r = a & b;
         3'b101: r = a | b;
         3'b010: r = a ^ b;
         3'b110: r = {b[15:0], 16'h0000};
         default: begin
            lat = int'(sh) + 1;
            if (!op[2])     r = b << sh;
            else if (op[3]) r = 32'($signed(b) >>> sh);
            else            r = b >> sh;
         end
      endcase
   endfunction

   // Call right after a negedge; returns at the negedge following the accept edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [3:0] tag);
      exp_t e;
      int   n;
      req_a = a; req_b = b; req_aluc = op; req_tag = tag; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
         return;
      end
      model(a, b, op, e.r, e.ovf, e.lat);
      e.tag = tag;
      e.acc = cyc;
      last_acc = cyc;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 64'(q.size()), 64'd0);
   endtask

   // Monitor samples just after the falling edge, once the driver has settled its inputs.
   always @(negedge clk) begin
      #1;
      if (rst_n && rsp_valid) begin
         if (q.size() == 0) begin
            check("spurious_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            if (!seen) begin
               check("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
               check("rsp_r", 64'(rsp_r), 64'(q[0].r));
               check("rsp_z", 64'(rsp_z), 64'(q[0].r == 32'd0));
               check("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
`ifdef ALU_OVF_FLAG_EN
               check("rsp_ovf", 64'(rsp_ovf), 64'(q[0].ovf));
`endif
               seen = 1'b1;
            end else begin
               check("hold_r", 64'(rsp_r), 64'(q[0].r));
               check("hold_z", 64'(rsp_z), 64'(q[0].r == 32'd0));
               check("hold_tag", 64'(rsp_tag), 64'(q[0].tag));
            end
            check("req_ready_busy", 64'(req_ready), 64'd0);
            if (rsp_ready) begin
               void'(q.pop_front());
               seen   = 1'b0;
               hs_cyc = cyc;
            end
         end
      end
   end

   initial begin
      int v;
      logic [31:0] ra, rb;
      logic [3:0]  rop, rtag;

      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_aluc = '0; req_tag = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_valid", 64'(rsp_valid), 64'd0);
      check("reset_r", 64'(rsp_r), 64'd0);
      check("reset_z", 64'(rsp_z), 64'd1);
      check("reset_tag", 64'(rsp_tag), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready", 64'(req_ready), 64'd1);

      // basic ops, including opcode aliases and wraparound
      send(32'd10, 32'd3, 4'b0000, 4'd5);
      send(32'd3, 32'd3, 4'b0100, 4'd1);
      send(32'd10, 32'd3, 4'b0001, 4'd2);
      send(32'd0, 32'h0000_1234, 4'b0110, 4'd3);
      send(32'hF0F0_0000, 32'h0000_0F0F, 4'b1101, 4'd4);
      send(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0010, 4'd6);
      send(32'hFFFF_FFFF, 32'd1, 4'b1000, 4'd7);
      send(32'd0, 32'd1, 4'b1100, 4'd8);
      // serial shifts, sh==0 bypass and maximum amount
      send(32'd4, 32'h8000_0000, 4'b1111, 4'd9);
      send(32'd4, 32'h8000_0000, 4'b0111, 4'd10);
      send(32'd0, 32'd7, 4'b0011, 4'd11);
      send(32'd31, 32'd1, 4'b1011, 4'd12);
      send(32'hFFFF_FFE1, 32'hC000_0000, 4'b1111, 4'd13);
      send(32'd31, 32'h8000_0000, 4'b0111, 4'd14);
      drain();

      // backpressure: response held 3 cycles while the next request waits
      rsp_ready = 1'b0;
      send(32'd100, 32'd23, 4'b0000, 4'd15);
      fork
         begin
            int n;
            n = 0;
            while (!rsp_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            check("bp_valid_seen", 64'(rsp_valid), 64'd1);
            repeat (3) @(negedge clk);
            rsp_ready = 1'b1;
         end
         send(32'd6, 32'd9, 4'b0101, 4'd0);
      join
      check("bp_accept_cycle", 64'(last_acc), 64'(hs_cyc + 1));
      drain();

      // async reset in the middle of a long shift
      send(32'd5, 32'd6, 4'b0000, 4'd3);
      drain();
      send(32'd20, 32'd1, 4'b0011, 4'd9);
      repeat (5) @(negedge clk);
      check("shift_busy_valid", 64'(rsp_valid), 64'd0);
      check("shift_busy_ready", 64'(req_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_valid", 64'(rsp_valid), 64'd0);
      check("abort_r", 64'(rsp_r), 64'd0);
      check("abort_z", 64'(rsp_z), 64'd1);
      check("abort_tag", 64'(rsp_tag), 64'd0);
      q.delete();
      seen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_ready", 64'(req_ready), 64'd1);
      v = 0;
      repeat (25) begin
         @(negedge clk);
         if (rsp_valid) v++;
      end
      check("abort_no_rsp", 64'(v), 64'd0);
      send(32'd1, 32'd1, 4'b0000, 4'd4);
      drain();

      // signed overflow corner cases
      send(32'h7FFF_FFFF, 32'd1, 4'b0000, 4'd1);
      send(32'h8000_0000, 32'd1, 4'b0100, 4'd2);
      send(32'd10, 32'd3, 4'b0000, 4'd3);
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0010, 4'd4);
      send(32'h8000_0000, 32'h8000_0000, 4'b1000, 4'd5);
      drain();

      // random mix over all opcodes
      for (int i = 0; i < 30; i++) begin
         ra   = $urandom;
         rb   = $urandom;
         rop  = 4'($urandom_range(0, 15));
         rtag = 4'($urandom_range(0, 15));
         send(ra, rb, rop, rtag);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
